alu_seq_param: RTL and testbench

//  Parametrised, registered successor of the 16-bit ripple ALU: WIDTH-bit operands,

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_1bit.sv | 34 +++
 rtl/alu_seq_param_comb.sv | 64 ++++++
 rtl/alu_seq_param.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq_param.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SLT = 3'b011,
      OP_MUL = 3'b100,
      OP_SLL = 3'b101,
      OP_SRL = 3'b110,
      OP_SRA = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // Ops 000-011 finish in the acceptance cycle; MUL and shifts iterate.
   function automatic logic is_single_cycle(input logic [2:0] op);
      return !op[2];
   endfunction

endpackage

// File: rtl/alu_1bit.sv
// One bit slice of the ripple ALU: AND / OR / full-add / pass-through of 'less'.
module alu_1bit (
   input  logic       a,
   input  logic       b,
   input  logic       ainvert,
   input  logic       bnegate,
   input  logic       carry_in,
   input  logic       less,
   input  logic [1:0] op,
   output logic       result,
   output logic       carry_out,
   output logic       sum
);

   logic a_x;
   logic b_x;

   assign a_x       = a ^ ainvert;
   assign b_x       = b ^ bnegate;
   assign sum       = a_x ^ b_x ^ carry_in;
   assign carry_out = (a_x & b_x) | (carry_in & (a_x ^ b_x));

   // Select the slice output for the low two opcode bits.
   always_comb begin
      result = 1'b0;
      case (op)
         2'b00:   result = a_x & b_x;
         2'b01:   result = a_x | b_x;
         2'b10:   result = sum;
         default: result = less;
      endcase
   end

endmodule

// File: rtl/alu_seq_param_comb.sv
// Combinational AND/OR/ADD/SLT stage built from a ripple chain of alu_1bit slices.
module alu_seq_param_comb #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             ainvert,
   input  logic             bnegate,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned MSB = WIDTH - 1;

   logic             bneg_eff;
   logic [WIDTH-1:0] sum_v;
   logic             a_msb;
   logic             b_msb;
   logic             ovf_raw;
   logic             set_lt;
   logic             unused_sum;

   // SLT is a subtract, so b is always negated for it.
   assign bneg_eff = bnegate | (op == 2'b11);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic cin;
      logic co;
      logic less_in;
      if (i == 0) begin : g_lsb
         assign cin     = bneg_eff;
         assign less_in = set_lt;
      end else begin : g_upper
         assign cin     = g_bit[i-1].co;
         assign less_in = 1'b0;
      end
      alu_1bit u_bit (
         .a         (a[i]),
         .b         (b[i]),
         .ainvert   (ainvert),
         .bnegate   (bneg_eff),
         .carry_in  (cin),
         .less      (less_in),
         .op        (op),
         .result    (result[i]),
         .carry_out (co),
         .sum       (sum_v[i])
      );
   end

   assign a_msb   = a[MSB] ^ ainvert;
   assign b_msb   = b[MSB] ^ bneg_eff;
   assign ovf_raw = (a_msb == b_msb) && (sum_v[MSB] != a_msb);
   assign set_lt  = sum_v[MSB] ^ ovf_raw;

   // Carry and overflow only mean something for the arithmetic ops.
   assign cout     = op[1] & g_bit[MSB].co;
   assign overflow = op[1] & ovf_raw;

   assign unused_sum = ^sum_v[WIDTH-2:0];

endmodule

// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with valid/ready handshakes; MUL and shifts iterate one bit per cycle.
module alu_seq_param #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             ainvert,
   input  logic             bnegate,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             overflow
);

   import alu_pkg::*;

   localparam int unsigned CW  = $clog2(WIDTH + 1);
   localparam int unsigned MSB = WIDTH - 1;

   state_e           state_q,     state_d;
   logic [2:0]       op_q,        op_d;
   logic [WIDTH-1:0] mc_q,        mc_d;
   logic [WIDTH-1:0] lo_q,        lo_d;
   logic [WIDTH-1:0] hi_q,        hi_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             cout_q,      cout_d;
   logic             zero_q,      zero_d;
   logic             ovf_q,       ovf_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q,  in_ready_d;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_cout;
   logic               alu_ovf;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     add_v;
   logic [2*WIDTH-1:0] prod_v;
   logic [WIDTH-1:0]   shift_v;

   alu_seq_param_comb #(.WIDTH(WIDTH)) u_comb (
      .a        (a),
      .b        (b),
      .op       (op[1:0]),
      .ainvert  (ainvert),
      .bnegate  (bnegate),
      .result   (alu_res),
      .cout     (alu_cout),
      .overflow (alu_ovf)
   );

   assign shamt = b[SHW-1:0];

   // Shift-add multiply step: conditionally add multiplicand to high half, then shift {carry,hi,lo} right.
   assign add_v  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mc_q}) : {1'b0, hi_q};
   assign prod_v = {add_v, lo_q[WIDTH-1:1]};

   // One-bit shift step for the latched shift op.
   always_comb begin
      shift_v = lo_q;
      case (op_q)
         OP_SLL:  shift_v = {lo_q[WIDTH-2:0], 1'b0};
         OP_SRL:  shift_v = {1'b0, lo_q[WIDTH-1:1]};
         default: shift_v = {lo_q[MSB], lo_q[WIDTH-1:1]};
      endcase
   end

   // Next-state and datapath update for IDLE/CALC/DONE.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mc_d     = mc_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d = op;
               mc_d = a;
               if (is_single_cycle(op)) begin
                  result_d = alu_res;
                  cout_d   = alu_cout;
                  ovf_d    = alu_ovf;
                  zero_d   = (alu_res == '0);
                  state_d  = S_DONE;
               end else if (op == OP_MUL) begin
                  hi_d    = '0;
                  lo_d    = b;
                  cnt_d   = CW'(WIDTH);
                  state_d = S_CALC;
               end else if (shamt == '0) begin
                  result_d = a;
                  cout_d   = 1'b0;
                  ovf_d    = 1'b0;
                  zero_d   = (a == '0);
                  state_d  = S_DONE;
               end else begin
                  lo_d    = a;
                  cnt_d   = CW'(shamt);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            cnt_d = cnt_q - CW'(1);
            if (op_q == OP_MUL) begin
               hi_d = prod_v[2*WIDTH-1:WIDTH];
               lo_d = prod_v[WIDTH-1:0];
            end else begin
               lo_d = shift_v;
            end
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               cout_d  = 1'b0;
               if (op_q == OP_MUL) begin
                  result_d = prod_v[WIDTH-1:0];
                  ovf_d    = |prod_v[2*WIDTH-1:WIDTH];
                  zero_d   = (prod_v[WIDTH-1:0] == '0);
               end else begin
                  result_d = shift_v;
                  ovf_d    = 1'b0;
                  zero_d   = (shift_v == '0);
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= 3'b000;
         mc_q        <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         mc_q        <= mc_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         cout_q      <= cout_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign cout      = cout_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Randomised bench for alu_seq_param at WIDTH=16 and WIDTH=32 against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq_param;

   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] a_drv;
   logic [31:0] b_drv;
   logic [2:0]  op_drv;
   logic        ainv_drv;
   logic        bneg_drv;
   logic        out_ready_drv;
   logic        in_valid16;
   logic        in_valid32;

   logic        in_ready16, out_valid16, cout16, zero16, ovf16;
   logic [15:0] result16;
   logic        in_ready32, out_valid32, cout32, zero32, ovf32;
   logic [31:0] result32;

   bit          sel32;
   logic        o_in_ready, o_out_valid, o_cout, o_zero, o_ovf;
   logic [31:0] o_result;

   int n_tests = 0;
   int n_fail  = 0;

   alu_seq_param #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .a         (a_drv[15:0]),
      .b         (b_drv[15:0]),
      .op        (op_drv),
      .ainvert   (ainv_drv),
      .bnegate   (bneg_drv),
      .out_valid (out_valid16),
      .out_ready (out_ready_drv),
      .result    (result16),
      .cout      (cout16),
      .zero      (zero16),
      .overflow  (ovf16)
   );

   alu_seq_param #(.WIDTH(32)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .a         (a_drv),
      .b         (b_drv),
      .op        (op_drv),
      .ainvert   (ainv_drv),
      .bnegate   (bneg_drv),
      .out_valid (out_valid32),
      .out_ready (out_ready_drv),
      .result    (result32),
      .cout      (cout32),
      .zero      (zero32),
      .overflow  (ovf32)
   );

   // View of whichever instance is under test.
   always_comb begin
      if (sel32) begin
         o_in_ready  = in_ready32;
         o_out_valid = out_valid32;
         o_result    = result32;
         o_cout      = cout32;
         o_zero      = zero32;
         o_ovf       = ovf32;
      end else begin
         o_in_ready  = in_ready16;
         o_out_valid = out_valid16;
         o_result    = {16'h0000, result16};
         o_cout      = cout16;
         o_zero      = zero16;
         o_ovf       = ovf16;
      end
   end

   typedef struct {
      logic [63:0] res;
      logic        cout;
      logic        ov;
      logic        zero;
      int          lat;
   } exp_t;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint sx(input int w, input logic [63:0] v);
      if (v[w-1]) return longint'(v) - (longint'(1) << w);
      return longint'(v);
   endfunction

   // Reference: true integer arithmetic on w-bit values (widths are powers of two).
   function automatic exp_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic [2:0] op, input logic ai, input logic bn);
      exp_t        e;
      logic [63:0] mask, a, b, aa, bb, s, p;
      longint      lim, ss, cin, t;
      int          n;
      mask  = (64'd1 << w) - 64'd1;
      a     = a_in & mask;
      b     = b_in & mask;
      aa    = ai ? (~a & mask) : a;
      bb    = (bn || op == OP_SLT) ? (~b & mask) : b;
      cin   = (bn || op == OP_SLT) ? 1 : 0;
      lim   = longint'(1) << (w - 1);
      e.res = 64'd0;
      e.cout = 1'b0;
      e.ov  = 1'b0;
      e.lat = 1;
      case (op)
         OP_AND: e.res = aa & bb;
         OP_OR:  e.res = aa | bb;
         OP_ADD, OP_SLT: begin
            s      = aa + bb + 64'(cin);
            e.cout = s[w];
            ss     = sx(w, aa) + sx(w, bb) + cin;
            e.ov   = (ss >= lim) || (ss < -lim);
            if (op == OP_ADD) e.res = s & mask;
            else              e.res = (sx(w, aa) < sx(w, b)) ? 64'd1 : 64'd0;
         end
         OP_MUL: begin
            p     = a * b;
            e.res = p & mask;
            e.ov  = ((p >> w) != 64'd0);
            e.lat = w + 1;
         end
         default: begin
            n     = int'(b & 64'(w - 1));
            e.lat = n + 1;
            if (op == OP_SLL)      e.res = (a << n) & mask;
            else if (op == OP_SRL) e.res = a >> n;
            else begin
               t     = sx(w, a) >>> n;
               e.res = 64'(t) & mask;
            end
         end
      endcase
      e.zero = (e.res == 64'd0);
      return e;
   endfunction

   // Issue one op, measure latency, check outputs, optionally stall the consumer, then drain.
   task automatic run_op(input bit w32, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic ai, input logic bn,
                         input int hold, input bit poke);
      exp_t        e;
      int          lat;
      bit          busy_ok;
      bit          stable_ok;
      logic [31:0] r0;
      logic        c0, z0, v0;
      sel32 = w32;
      e = model(w32 ? 32 : 16, {32'h0, a}, {32'h0, b}, op, ai, bn);
      @(negedge clk);
      check("idle_in_ready", 64'(o_in_ready), 64'd1);
      a_drv = a; b_drv = b; op_drv = op; ainv_drv = ai; bneg_drv = bn;
      out_ready_drv = 1'b0;
      if (w32) in_valid32 = 1'b1; else in_valid16 = 1'b1;
      lat = 0;
      busy_ok = 1'b1;
      do begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (!o_out_valid) begin
            if (o_in_ready) busy_ok = 1'b0;
            if (poke) begin
               a_drv  = $urandom;
               b_drv  = $urandom;
               op_drv = 3'($urandom_range(0, 7));
            end else begin
               in_valid16 = 1'b0;
               in_valid32 = 1'b0;
            end
         end
      end while (!o_out_valid && lat < 100);
      in_valid16 = 1'b0;
      in_valid32 = 1'b0;
      check("latency",   64'(lat), 64'(e.lat));
      check("result",    64'(o_result), e.res);
      check("cout",      64'(o_cout), 64'(e.cout));
      check("overflow",  64'(o_ovf), 64'(e.ov));
      check("zero",      64'(o_zero), 64'(e.zero));
      check("busy_ready", 64'(busy_ok && !o_in_ready), 64'd1);
      r0 = o_result; c0 = o_cout; z0 = o_zero; v0 = o_ovf;
      if (hold > 0) begin
         stable_ok = 1'b1;
         repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            if (!o_out_valid || o_in_ready || o_result !== r0 || o_cout !== c0 ||
                o_zero !== z0 || o_ovf !== v0) stable_ok = 1'b0;
         end
         check("hold_stable", 64'(stable_ok), 64'd1);
      end
      out_ready_drv = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready_drv = 1'b0;
      check("drain", {62'd0, o_out_valid, o_in_ready}, 64'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_drv = '0; b_drv = '0; op_drv = '0; ainv_drv = 1'b0; bneg_drv = 1'b0;
      out_ready_drv = 1'b0; in_valid16 = 1'b0; in_valid32 = 1'b0; sel32 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid16", 64'(out_valid16), 64'd0);
      check("rst_result16",    64'(result16), 64'd0);
      check("rst_flags16",     {61'd0, cout16, zero16, ovf16}, 64'd0);
      check("rst_out_valid32", 64'(out_valid32), 64'd0);
      check("rst_result32",    64'(result32), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rel_in_ready16", 64'(in_ready16), 64'd1);
      check("rel_in_ready32", 64'(in_ready32), 64'd1);

      // Directed corner cases at WIDTH=16.
      run_op(1'b0, 32'h7FFF, 32'h0001, OP_ADD, 1'b0, 1'b0, 0, 1'b0);
      run_op(1'b0, 32'h1234, 32'h1234, OP_ADD, 1'b0, 1'b1, 0, 1'b0);
      run_op(1'b0, 32'h8000, 32'h0001, OP_SLT, 1'b0, 1'b0, 0, 1'b0);
      run_op(1'b0, 32'h0001, 32'h8000, OP_SLT, 1'b0, 1'b0, 0, 1'b0);
      run_op(1'b0, 32'h0100, 32'h0101, OP_MUL, 1'b0, 1'b0, 0, 1'b1);
      run_op(1'b0, 32'h8000, 32'h0004, OP_SRA, 1'b0, 1'b0, 0, 1'b0);
      run_op(1'b0, 32'hA5C3, 32'h0000, OP_SLL, 1'b1, 1'b1, 0, 1'b0);
      run_op(1'b0, 32'h8001, 32'h000F, OP_SRL, 1'b0, 1'b0, 0, 1'b0);
      run_op(1'b0, 32'h0100, 32'h0101, OP_MUL, 1'b0, 1'b0, 10, 1'b0);

      // Reset in the middle of a multiply must abort it.
      @(negedge clk);
      sel32 = 1'b0;
      a_drv = 32'h0100; b_drv = 32'h0101; op_drv = OP_MUL; in_valid16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid16 = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_busy", 64'(in_ready16), 64'd0);
      rst = 1'b1;
      #1;
      check("abort_out_valid", 64'(out_valid16), 64'd0);
      check("abort_result",    64'(result16), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", 64'(in_ready16), 64'd1);
      repeat (20) @(negedge clk);
      check("abort_no_output", 64'(out_valid16), 64'd0);

      // Randomised traffic at WIDTH=16.
      for (int i = 0; i < 120; i++) begin
         run_op(1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      // WIDTH=32 directed and random.
      run_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, 0, 1'b0);
      run_op(1'b1, 32'h0001_0000, 32'h0001_0001, OP_MUL, 1'b0, 1'b0, 0, 1'b1);
      run_op(1'b1, 32'h8000_0000, 32'h0000_001F, OP_SRA, 1'b0, 1'b0, 2, 1'b0);
      for (int i = 0; i < 30; i++) begin
         run_op(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
